// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared CPU types: the machine word, register index, the memory-stage
//   state encoding and a helper that forms the LUI writeback value.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  // IDLE   : no access in flight
  // ACCESS : request outstanding, waiting for dhit
  // HOLD   : access done but pipeline frozen; load data parked in hold register
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } memstate_t;

  // Upper-immediate value: instruction immediate in the top half, zeros below.
  function automatic word_t luiValue(input word_t instr);
    return {instr[15:0], 16'h0000};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if
//   Data-cache bus between the memory stage (master) and the data cache
//   (slave).
//   dmemREN/dmemWEN : read / write request
//   dmemaddr        : access address
//   dmemstore       : store data
//   dhit            : cache completes the access this cycle
//   dmemload        : load data, valid when dhit
interface mem_stage_if;
  import cpu_types_pkg::*;

  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  dhit;
  word_t dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage
//   Memory-stage controller. Issues data-cache requests from the EX/MEM
//   latch contents, stalls upstream stages while a miss is outstanding,
//   selects the writeback value and owns the MEM/WB register (bubbles on
//   miss, hold on freeze, sticky halt).
//   CLK, nRST        : clock, synchronous active-low reset
//   memcu*/mem*      : EX/MEM control, destination, address, store data, instr
//   pipeStall        : global freeze from elsewhere in the pipeline
//   dbus             : data-cache bus (master side)
//   memStall         : freezes PC, IF/ID, ID/EX, EX/MEM
//   wb*              : MEM/WB register outputs
//   memStallCount    : saturating count of memStall cycles
module mem_stage
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     memcuDRE,
  input  logic     memcuDWE,
  input  logic     memcuHALT,
  input  logic     memMemToReg,
  input  logic     memWEN,
  input  logic     memLUIflag,
  input  regbits_t memwsel,
  input  word_t    memOutput_Port,
  input  word_t    memrdat2,
  input  word_t    meminstr,
  input  logic     pipeStall,
  mem_stage_if.master dbus,
  output logic     memStall,
  output logic     wbWEN,
  output regbits_t wbwsel,
  output word_t    wbwdat,
  output word_t    wbinstr,
  output logic     wbHALT,
  output word_t    memStallCount
);

  memstate_t state;
  word_t     holdData;
  word_t     wdatNext;
  logic      req;
  logic      accessHit;

  // No new requests after halt, and none while the completed access is parked.
  assign req       = (memcuDRE | memcuDWE) & ~wbHALT & (state != HOLD);
  assign accessHit = req & dbus.dhit;   // a dhit without a request is ignored
  assign memStall  = req & ~dbus.dhit;

  // Write wins when both request bits are set.
  assign dbus.dmemWEN   = req & memcuDWE;
  assign dbus.dmemREN   = req & memcuDRE & ~memcuDWE;
  assign dbus.dmemaddr  = memOutput_Port;
  assign dbus.dmemstore = memrdat2;

  always_comb begin
    wdatNext = memOutput_Port;
    if (memMemToReg) begin
      wdatNext = (state == HOLD) ? holdData : dbus.dmemload;
    end else if (memLUIflag) begin
      wdatNext = luiValue(meminstr);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state         <= IDLE;
      holdData      <= '0;
      wbWEN         <= 1'b0;
      wbwsel        <= '0;
      wbwdat        <= '0;
      wbinstr       <= '0;
      wbHALT        <= 1'b0;
      memStallCount <= '0;
    end else begin
      case (state)
        IDLE, ACCESS: begin
          if (accessHit && pipeStall) begin
            // Cache data is only valid this cycle; park it until the freeze lifts.
            state    <= HOLD;
            holdData <= dbus.dmemload;
          end else if (memStall) begin
            state <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (!pipeStall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (!pipeStall) begin
        if (memStall) begin
          wbWEN   <= 1'b0;
          wbwsel  <= '0;
          wbwdat  <= '0;
          wbinstr <= '0;
        end else begin
          // Old wbHALT: the halting instruction itself keeps its own WEN.
          wbWEN   <= memWEN & ~wbHALT;
          wbwsel  <= memwsel;
          wbwdat  <= wdatNext;
          wbinstr <= meminstr;
          wbHALT  <= wbHALT | memcuHALT;
        end
      end

      if (memStall && (memStallCount != '1)) begin
        memStallCount <= memStallCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import cpu_types_pkg::*;

  logic     CLK;
  logic     nRST;
  logic     memcuDRE, memcuDWE, memcuHALT, memMemToReg, memWEN, memLUIflag;
  regbits_t memwsel;
  word_t    memOutput_Port, memrdat2, meminstr;
  logic     pipeStall;
  logic     memStall, wbWEN, wbHALT;
  regbits_t wbwsel;
  word_t    wbwdat, wbinstr, memStallCount;

  int checks = 0;
  int errors = 0;

  mem_stage_if dbus();

  mem_stage dut (
    .CLK(CLK), .nRST(nRST),
    .memcuDRE(memcuDRE), .memcuDWE(memcuDWE), .memcuHALT(memcuHALT),
    .memMemToReg(memMemToReg), .memWEN(memWEN), .memLUIflag(memLUIflag),
    .memwsel(memwsel), .memOutput_Port(memOutput_Port), .memrdat2(memrdat2),
    .meminstr(meminstr), .pipeStall(pipeStall), .dbus(dbus.master),
    .memStall(memStall), .wbWEN(wbWEN), .wbwsel(wbwsel), .wbwdat(wbwdat),
    .wbinstr(wbinstr), .wbHALT(wbHALT), .memStallCount(memStallCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idleInputs();
    memcuDRE = 0; memcuDWE = 0; memcuHALT = 0; memMemToReg = 0; memWEN = 0;
    memLUIflag = 0; memwsel = '0; memOutput_Port = '0; memrdat2 = '0;
    meminstr = '0; pipeStall = 0; dbus.dhit = 0; dbus.dmemload = '0;
  endtask

  task automatic doReset();
    nRST = 0; idleInputs(); tick(); nRST = 1;
  endtask

  task automatic test_reset();
    nRST = 0; idleInputs();
    memwsel = 5'd7; memOutput_Port = 32'h55; memWEN = 1;
    tick(); tick();
    checks++; if (wbWEN !== 1'b0) begin errors++; $display("FAIL reset_wbWEN: got %b expected 0", wbWEN); end
    checks++; if (wbwsel !== 5'd0) begin errors++; $display("FAIL reset_wbwsel: got %0d expected 0", wbwsel); end
    checks++; if (wbwdat !== 32'h0) begin errors++; $display("FAIL reset_wbwdat: got %h expected 0", wbwdat); end
    checks++; if (wbHALT !== 1'b0) begin errors++; $display("FAIL reset_wbHALT: got %b expected 0", wbHALT); end
    checks++; if (memStallCount !== 32'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", memStallCount); end
    // combinational outputs follow inputs while reset is held
    memcuDRE = 1; #1;
    checks++; if (dbus.dmemREN !== 1'b1) begin errors++; $display("FAIL reset_ren_follow: got %b expected 1", dbus.dmemREN); end
    checks++; if (memStall !== 1'b1) begin errors++; $display("FAIL reset_stall_follow: got %b expected 1", memStall); end
    tick();
    checks++; if (memStallCount !== 32'h0) begin errors++; $display("FAIL reset_count_held: got %h expected 0", memStallCount); end
    nRST = 1; idleInputs(); tick();
    $display("test_reset done");
  endtask

  task automatic test_load_hit();
    doReset();
    memcuDRE = 1; memOutput_Port = 32'h100; dbus.dhit = 1; dbus.dmemload = 32'hDEADBEEF;
    memMemToReg = 1; memWEN = 1; memwsel = 5'd5; meminstr = 32'h8C450000; #1;
    checks++; if (memStall !== 1'b0) begin errors++; $display("FAIL hit_stall: got %b expected 0", memStall); end
    checks++; if (dbus.dmemREN !== 1'b1) begin errors++; $display("FAIL hit_ren: got %b expected 1", dbus.dmemREN); end
    checks++; if (dbus.dmemaddr !== 32'h100) begin errors++; $display("FAIL hit_addr: got %h expected 100", dbus.dmemaddr); end
    tick();
    checks++; if (wbWEN !== 1'b1) begin errors++; $display("FAIL hit_wbWEN: got %b expected 1", wbWEN); end
    checks++; if (wbwsel !== 5'd5) begin errors++; $display("FAIL hit_wbwsel: got %0d expected 5", wbwsel); end
    checks++; if (wbwdat !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_wbwdat: got %h expected deadbeef", wbwdat); end
    checks++; if (wbinstr !== 32'h8C450000) begin errors++; $display("FAIL hit_wbinstr: got %h expected 8c450000", wbinstr); end
    checks++; if (memStallCount !== 32'h0) begin errors++; $display("FAIL hit_count: got %h expected 0", memStallCount); end
    idleInputs();
    $display("test_load_hit done");
  endtask

  task automatic test_store_miss();
    int wenCycles = 0;
    int stallCycles = 0;
    doReset();
    memcuDWE = 1; memcuDRE = 1; memrdat2 = 32'h1234; memOutput_Port = 32'h40;
    memwsel = 5'd9; meminstr = 32'hAD001234;
    for (int i = 0; i < 4; i++) begin
      dbus.dhit = (i == 3); #1;
      if (dbus.dmemWEN === 1'b1) wenCycles++;
      if (memStall === 1'b1) stallCycles++;
      checks++; if (dbus.dmemREN !== 1'b0) begin errors++; $display("FAIL miss_ren_c%0d: got %b expected 0", i, dbus.dmemREN); end
      checks++; if (dbus.dmemstore !== 32'h1234) begin errors++; $display("FAIL miss_store_c%0d: got %h expected 1234", i, dbus.dmemstore); end
      tick();
      if (i < 3) begin
        checks++; if (wbwsel !== 5'd0 || wbinstr !== 32'h0 || wbWEN !== 1'b0) begin errors++; $display("FAIL miss_bubble_c%0d: got wsel=%0d instr=%h wen=%b expected 0/0/0", i, wbwsel, wbinstr, wbWEN); end
      end else begin
        checks++; if (wbwsel !== 5'd9 || wbinstr !== 32'hAD001234 || wbwdat !== 32'h40) begin errors++; $display("FAIL miss_advance: got wsel=%0d instr=%h wdat=%h expected 9/ad001234/40", wbwsel, wbinstr, wbwdat); end
      end
    end
    checks++; if (wenCycles != 4) begin errors++; $display("FAIL miss_wen_cycles: got %0d expected 4", wenCycles); end
    checks++; if (stallCycles != 3) begin errors++; $display("FAIL miss_stall_cycles: got %0d expected 3", stallCycles); end
    checks++; if (memStallCount !== 32'd3) begin errors++; $display("FAIL miss_count: got %0d expected 3", memStallCount); end
    idleInputs();
    $display("test_store_miss done");
  endtask

  task automatic test_hit_under_freeze();
    doReset();
    memcuDRE = 1; memMemToReg = 1; memWEN = 1; memwsel = 5'd3; memOutput_Port = 32'h200;
    meminstr = 32'h8C030200;
    tick();                                   // miss cycle -> ACCESS, bubble
    dbus.dhit = 1; dbus.dmemload = 32'h11112222; pipeStall = 1; #1;
    checks++; if (memStall !== 1'b0) begin errors++; $display("FAIL frz_stall_at_hit: got %b expected 0", memStall); end
    tick();                                   // -> HOLD
    dbus.dhit = 0; dbus.dmemload = 32'h99999999;
    for (int i = 0; i < 2; i++) begin
      pipeStall = (i == 0); #1;
      if (i == 0) begin
        checks++; if (dbus.dmemREN !== 1'b0) begin errors++; $display("FAIL frz_ren_hold: got %b expected 0", dbus.dmemREN); end
        checks++; if (wbWEN !== 1'b0 || wbwsel !== 5'd0) begin errors++; $display("FAIL frz_wb_held: got wen=%b wsel=%0d expected 0/0", wbWEN, wbwsel); end
      end
      tick();
    end
    // freeze dropped in the second loop cycle: exactly one writeback
    checks++; if (wbwdat !== 32'h11112222) begin errors++; $display("FAIL frz_wbwdat: got %h expected 11112222", wbwdat); end
    checks++; if (wbWEN !== 1'b1 || wbwsel !== 5'd3) begin errors++; $display("FAIL frz_wb_ctrl: got wen=%b wsel=%0d expected 1/3", wbWEN, wbwsel); end
    idleInputs(); tick();
    checks++; if (wbWEN !== 1'b0) begin errors++; $display("FAIL frz_single_wb: got %b expected 0", wbWEN); end
    $display("test_hit_under_freeze done");
  endtask

  task automatic test_lui();
    doReset();
    memLUIflag = 1; meminstr = 32'h3C01ABCD; memOutput_Port = 32'h55; memWEN = 1; memwsel = 5'd1;
    tick();
    checks++; if (wbwdat !== 32'hABCD0000) begin errors++; $display("FAIL lui_wbwdat: got %h expected abcd0000", wbwdat); end
    idleInputs();
    $display("test_lui done");
  endtask

  task automatic test_halt();
    doReset();
    memcuHALT = 1; meminstr = 32'hFFFFFFFF;
    tick();
    checks++; if (wbHALT !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", wbHALT); end
    idleInputs();
    memcuDRE = 1; memMemToReg = 1; memWEN = 1; memwsel = 5'd4; #1;
    checks++; if (dbus.dmemREN !== 1'b0 || memStall !== 1'b0) begin errors++; $display("FAIL halt_no_req: got ren=%b stall=%b expected 0/0", dbus.dmemREN, memStall); end
    tick(); tick();
    checks++; if (wbWEN !== 1'b0 || wbHALT !== 1'b1) begin errors++; $display("FAIL halt_sticky: got wen=%b halt=%b expected 0/1", wbWEN, wbHALT); end
    doReset();
    checks++; if (wbHALT !== 1'b0) begin errors++; $display("FAIL halt_reset: got %b expected 0", wbHALT); end
    idleInputs();
    $display("test_halt done");
  endtask

  task automatic test_reset_mid_miss();
    doReset();
    memcuDRE = 1; memMemToReg = 1; memWEN = 1; memwsel = 5'd6; dbus.dhit = 1; dbus.dmemload = 32'hCAFE0001;
    tick();                                   // hit: wb loaded
    dbus.dhit = 0; pipeStall = 1;
    tick(); tick();                           // miss under freeze: wb held, count 2
    checks++; if (wbwsel !== 5'd6 || memStallCount !== 32'd2) begin errors++; $display("FAIL rmm_pre: got wsel=%0d cnt=%0d expected 6/2", wbwsel, memStallCount); end
    nRST = 0; tick(); nRST = 1;
    checks++; if (wbwsel !== 5'd0 || wbwdat !== 32'h0 || wbWEN !== 1'b0 || memStallCount !== 32'h0) begin errors++; $display("FAIL rmm_clear: got wsel=%0d wdat=%h wen=%b cnt=%0d expected zeros", wbwsel, wbwdat, wbWEN, memStallCount); end
    pipeStall = 0; dbus.dhit = 1; dbus.dmemload = 32'hCAFE0002; #1;
    checks++; if (dbus.dmemREN !== 1'b1) begin errors++; $display("FAIL rmm_reissue: got %b expected 1", dbus.dmemREN); end
    tick();
    checks++; if (wbwdat !== 32'hCAFE0002) begin errors++; $display("FAIL rmm_result: got %h expected cafe0002", wbwdat); end
    idleInputs();
    $display("test_reset_mid_miss done");
  endtask

  task automatic test_saturation();
    doReset();
    force dut.memStallCount = 32'hFFFFFFFE;
    #1;
    release dut.memStallCount;
    memcuDRE = 1;
    tick(); tick(); tick();
    checks++; if (memStallCount !== 32'hFFFFFFFF) begin errors++; $display("FAIL sat_count: got %h expected ffffffff", memStallCount); end
    idleInputs();
    $display("test_saturation done");
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_store_miss();
    test_hit_under_freeze();
    test_lui();
    test_halt();
    test_reset_mid_miss();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-stage controller of the five-stage pipeline; sits on the output side of the EX/MEM latch and the input side of the MEM/WB latch. Consumes the EX/MEM outputs, issues data-cache read/write requests with a dhit handshake, and stalls earlier stages during misses. Selects the writeback value and owns the MEM/WB register, with bubble insertion, hold-on-freeze and sticky halt.

## Interface
Parameters:
- none; widths come from cpu_types_pkg (word_t = 32 bits)

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- nRST  in  1  reset, synchronous, active-low
- memcuDRE, memcuDWE  in  1 each  load / store request from EX/MEM
- memcuHALT, memMemToReg, memWEN, memLUIflag  in  1 each  control from EX/MEM
- memwsel  in  5  destination register
- memOutput_Port, memrdat2, meminstr  in  32 each  ALU result (address), store data, instruction
- dhit  in  1  data cache completes access this cycle
- dmemload  in  32  load data, valid when dhit
- pipeStall  in  1  global freeze (e.g. instruction miss)
- dmemREN, dmemWEN  out  1 each  cache request
- dmemaddr, dmemstore  out  32 each  = memOutput_Port, memrdat2
- memStall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM
- wbWEN  out  1  registered write enable
- wbwsel  out  5  registered destination
- wbwdat  out  32  registered writeback value
- wbinstr  out  32  registered instruction
- wbHALT  out  1  sticky halt
- memStallCount  out  32  saturating count of memStall cycles

## Operation
- States: IDLE, ACCESS, HOLD.
- Request: req = (memcuDRE | memcuDWE) & ~wbHALT & state≠HOLD.
- If both DRE and DWE are set, treat the access as a write: dmemWEN=1, dmemREN=0.
- dmemREN/dmemWEN are combinational from req. They stay asserted in ACCESS until dhit.
- IDLE→ACCESS: req & ~dhit.
- ACCESS→IDLE: dhit & ~pipeStall.
- IDLE/ACCESS→HOLD: dhit & pipeStall. In this case, capture dmemload into the hold register.
- HOLD→IDLE: ~pipeStall. In HOLD, requests are deasserted and wbwdat uses the hold register.
- memStall = req & ~dhit.
- Writeback value:
  - MemToReg: dmemload, or the hold register when in HOLD.
  - else if LUIflag: {meminstr[15:0],16'h0000}.
  - else: memOutput_Port.
- Writeback-register update rules:
  - advance (~memStall & ~pipeStall): load wbWEN=memWEN, wbwsel, wbwdat, wbinstr, wbHALT|=memcuHALT.
  - memStall & ~pipeStall: load a bubble (wbWEN=0, wbwsel=0, wbwdat=0, wbinstr=0).
  - pipeStall: hold all wb outputs.
- Halt:
  - Once wbHALT=1, no further requests are issued.
  - wbWEN is forced to 0 on later advances.
  - wbHALT clears only on reset.
- memStallCount increments each cycle memStall=1. It saturates at 32'hFFFF_FFFF.
- dhit with no outstanding request is ignored.

## Timing
- Reset values (nRST=0 at edge): state IDLE; all wb outputs 0; hold register 0; memStallCount 0.
- Combinational outputs with reset asserted: dmemREN/dmemWEN/memStall follow the inputs.
- A hit in the request cycle gives zero stall cycles; the result appears in wb* at the next edge.
- A miss resolved after N cycles gives memStall high for N cycles and N bubbles into MEM/WB.
- Reset mid-ACCESS: the next cycle starts in IDLE. A still-present request is reissued; there is no partial state.
- dhit and pipeStall in the same cycle: HOLD, the data is kept, and exactly one writeback occurs when the freeze lifts.
- memcuHALT together with a memory op: the op completes first, then wbHALT sets on that advance.

## Structure
- cpu_types_pkg gains memstate_t (IDLE, ACCESS, HOLD). The package already provides word_t and regbits.
- Single module with no sub-module. The MEM/WB register lives inside. The saturating counter is a few lines inline.

## Test plan
- Load hit: DRE=1, addr 0x100, dhit=1 same cycle, dmemload 0xDEADBEEF, MemToReg=1, wsel=5 -> memStall never high; next edge wbWEN=1, wbwsel=5, wbwdat=0xDEADBEEF.
- Store miss, 3 wait cycles: DWE=1, rdat2 0x1234 -> dmemWEN high 4 cycles, memStall high 3; 3 bubbles (wbWEN=0); memStallCount=3; dmemstore=0x1234 throughout.
- dhit under pipeStall: load completes with pipeStall=1 for 2 more cycles, dmemload changes after the hit -> state HOLD, requests low, wb outputs held; one cycle after pipeStall drops, wbwdat = value captured at the hit.
- LUI: LUIflag=1, instr[15:0]=0xABCD, no mem op -> wbwdat=0xABCD0000 next edge.
- Halt: HALT instr advances, then a later load is presented -> wbHALT=1 sticky, dmemREN stays 0, wbWEN stays 0; reset clears all.
- Reset mid-miss and saturation: nRST=0 during ACCESS -> all wb outputs 0 and counter 0 next cycle; preload the counter to 0xFFFFFFFE with 3 stall cycles -> counter reads 0xFFFFFFFF.
